// File: rtl/cgra_banked_tile_mem_pkg.sv
// rtl/cgra_banked_tile_mem_pkg.sv - shared types and helpers for the banked tile memory
package cgra_mem_pkg;

  typedef enum logic [1:0] {GNT_NONE, GNT_PE, GNT_EXT} gnt_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/cgra_banked_tile_mem_if.sv
// rtl/cgra_banked_tile_mem_if.sv - PE row ports and shared ext port of the tile memory
interface cgra_banked_tile_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BSEL_WIDTH = 2
);
  logic [NUM_BANKS-1:0]            pe_req;
  logic [NUM_BANKS-1:0]            pe_we;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] pe_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] pe_wdata;
  logic [NUM_BANKS-1:0]            pe_ready;
  logic [NUM_BANKS*DATA_WIDTH-1:0] pe_rdata;
  logic [NUM_BANKS-1:0]            pe_rvalid;
  logic                            ext_req;
  logic                            ext_we;
  logic [BSEL_WIDTH-1:0]           ext_bank;
  logic [ADDR_WIDTH-1:0]           ext_addr;
  logic [DATA_WIDTH-1:0]           ext_wdata;
  logic [DATA_WIDTH/8-1:0]         ext_be;
  logic                            ext_ready;
  logic [DATA_WIDTH-1:0]           ext_rdata;
  logic                            ext_rvalid;
  logic                            ext_err;

  modport master (
    output pe_req, pe_we, pe_addr, pe_wdata, ext_req, ext_we, ext_bank, ext_addr, ext_wdata, ext_be,
    input  pe_ready, pe_rdata, pe_rvalid, ext_ready, ext_rdata, ext_rvalid, ext_err
  );

  modport slave (
    input  pe_req, pe_we, pe_addr, pe_wdata, ext_req, ext_we, ext_bank, ext_addr, ext_wdata, ext_be,
    output pe_ready, pe_rdata, pe_rvalid, ext_ready, ext_rdata, ext_rvalid, ext_err
  );
endinterface

// File: rtl/cgra_banked_tile_mem_bank.sv
// rtl/cgra_banked_tile_mem_bank.sv - single-port byte-enable RAM with 1-cycle registered read
module cgra_mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(BANK_DEPTH)
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/cgra_banked_tile_mem.sv
// rtl/cgra_banked_tile_mem.sv - row-banked tile memory, PE-first arbitration with ext starvation guard
module cgra_banked_tile_mem
  import cgra_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BANK_DEPTH   = 1024,
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_WIDTH   = $clog2(BANK_DEPTH),
  parameter int BSEL_WIDTH   = $clog2(NUM_BANKS),
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  cgra_banked_tile_mem_if.slave bus
);

  localparam int AW  = ADDR_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int NBE = DATA_WIDTH / 8;
  localparam int WCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] STARVE_MAX = WCW'(STARVE_LIMIT);

  gnt_t                 gnt [NUM_BANKS];
  logic [NUM_BANKS-1:0] ext_win;
  logic [NUM_BANKS-1:0] pe_addr_ok;
  logic                 ext_bank_ok;
  logic                 ext_addr_ok;
  logic [WCW-1:0]       wait_cnt;

  logic                 b_en    [NUM_BANKS];
  logic                 b_we    [NUM_BANKS];
  logic [AW-1:0]        b_addr  [NUM_BANKS];
  logic [DW-1:0]        b_wdata [NUM_BANKS];
  logic [NBE-1:0]       b_be    [NUM_BANKS];
  logic [DW-1:0]        b_q     [NUM_BANKS];

  logic [NUM_BANKS-1:0]    pe_rvalid_q, pe_zero_q;
  logic [NUM_BANKS*DW-1:0] pe_hold;
  logic                    ext_rvalid_q, ext_err_q, ext_zero_q;
  logic [BSEL_WIDTH-1:0]   ext_sel_q;
  logic [DW-1:0]           ext_hold, ext_now;

  always_comb begin
    ext_bank_ok = 32'(bus.ext_bank) < 32'(NUM_BANKS);
    ext_addr_ok = addr_in_range(32'(bus.ext_addr), 32'(BANK_DEPTH));
    for (int b = 0; b < NUM_BANKS; b++) begin
      pe_addr_ok[b] = addr_in_range(32'(bus.pe_addr[b*AW +: AW]), 32'(BANK_DEPTH));
      ext_win[b]    = bus.ext_req && (32'(bus.ext_bank) == 32'(b)) &&
                      (!bus.pe_req[b] || wait_cnt == STARVE_MAX);
      if (ext_win[b])          gnt[b] = GNT_EXT;
      else if (bus.pe_req[b])  gnt[b] = GNT_PE;
      else                     gnt[b] = GNT_NONE;
    end
    bus.pe_ready  = bus.pe_req & ~ext_win;
    // An invalid bank select never touches a bank, so it is granted at once.
    bus.ext_ready = bus.ext_req && (!ext_bank_ok || (|ext_win));
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic sel_ext;
    assign sel_ext    = (gnt[g] == GNT_EXT);
    assign b_en[g]    = sel_ext ? ext_addr_ok : ((gnt[g] == GNT_PE) && pe_addr_ok[g]);
    assign b_we[g]    = sel_ext ? bus.ext_we : bus.pe_we[g];
    assign b_addr[g]  = sel_ext ? bus.ext_addr : bus.pe_addr[g*AW +: AW];
    assign b_wdata[g] = sel_ext ? bus.ext_wdata : bus.pe_wdata[g*DW +: DW];
    assign b_be[g]    = sel_ext ? bus.ext_be : {NBE{1'b1}};

    cgra_mem_bank #(.DATA_WIDTH(DW), .BANK_DEPTH(BANK_DEPTH), .ADDR_WIDTH(AW)) u_bank (
      .clk   (clk),
      .en    (b_en[g]),
      .we    (b_we[g]),
      .addr  (b_addr[g]),
      .wdata (b_wdata[g]),
      .be    (b_be[g]),
      .rdata (b_q[g])
    );
  end

  assign ext_now = ext_zero_q ? '0 : b_q[ext_sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      pe_rvalid_q  <= '0;
      pe_zero_q    <= '0;
      pe_hold      <= '0;
      ext_rvalid_q <= 1'b0;
      ext_err_q    <= 1'b0;
      ext_zero_q   <= 1'b0;
      ext_sel_q    <= '0;
      ext_hold     <= '0;
    end else begin
      if (!bus.ext_req || bus.ext_ready) wait_cnt <= '0;
      else if (wait_cnt != STARVE_MAX)   wait_cnt <= wait_cnt + 1'b1;

      pe_rvalid_q <= bus.pe_req & bus.pe_ready & ~bus.pe_we;
      pe_zero_q   <= ~pe_addr_ok;
      // rdata is live from the bank during the rvalid cycle, then frozen in hold.
      for (int r = 0; r < NUM_BANKS; r++) begin
        if (pe_rvalid_q[r]) pe_hold[r*DW +: DW] <= pe_zero_q[r] ? '0 : b_q[r];
      end

      ext_rvalid_q <= bus.ext_req && bus.ext_ready && !bus.ext_we;
      ext_err_q    <= bus.ext_req && bus.ext_ready && !(ext_bank_ok && ext_addr_ok);
      ext_zero_q   <= !(ext_bank_ok && ext_addr_ok);
      ext_sel_q    <= ext_bank_ok ? bus.ext_bank : '0;
      if (ext_rvalid_q) ext_hold <= ext_now;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_BANKS; r++) begin
      bus.pe_rdata[r*DW +: DW] = pe_rvalid_q[r] ? (pe_zero_q[r] ? '0 : b_q[r]) : pe_hold[r*DW +: DW];
    end
    bus.pe_rvalid  = pe_rvalid_q;
    bus.ext_rdata  = ext_rvalid_q ? ext_now : ext_hold;
    bus.ext_rvalid = ext_rvalid_q;
    bus.ext_err    = ext_err_q;
  end

endmodule

// File: tb/tb_cgra_banked_tile_mem.sv
// tb/tb_cgra_banked_tile_mem.sv - scoreboard bench for the banked tile memory
module tb_cgra_banked_tile_mem;

  localparam int DW = 32, NB = 4, DEPTH = 1000, AW = 10, BW = 2, SL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cgra_banked_tile_mem_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .BSEL_WIDTH(BW)) bus ();

  cgra_banked_tile_mem #(
    .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .NUM_BANKS(NB),
    .ADDR_WIDTH(AW), .BSEL_WIDTH(BW), .STARVE_LIMIT(SL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [31:0] data; int cyc; } pe_exp_t;
  typedef struct { logic [31:0] data; logic is_read; logic err; int cyc; } ext_exp_t;

  logic [31:0] model [NB][DEPTH];
  pe_exp_t     pe_q [NB][$];
  ext_exp_t    ext_q [$];
  pe_exp_t     pe_e;
  ext_exp_t    ext_e;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < NB; r++) begin
        if (pe_q[r].size() > 0 && pe_q[r][0].cyc < cyc) begin
          pe_e = pe_q[r].pop_front();
          checks++; errors++;
          $display("FAIL pe_rvalid_missing port %0d expected at cycle %0d, now %0d", r, pe_e.cyc, cyc);
        end
        if (bus.pe_rvalid[r]) begin
          checks++;
          if (pe_q[r].size() == 0) begin
            errors++;
            $display("FAIL pe_rvalid_unexpected port %0d data %h", r, bus.pe_rdata[r*DW +: DW]);
          end else begin
            pe_e = pe_q[r].pop_front();
            if (bus.pe_rdata[r*DW +: DW] !== pe_e.data || cyc != pe_e.cyc) begin
              errors++;
              $display("FAIL pe_rdata port %0d got %h at cycle %0d, expected %h at cycle %0d",
                       r, bus.pe_rdata[r*DW +: DW], cyc, pe_e.data, pe_e.cyc);
            end
          end
        end
      end
      if (ext_q.size() > 0 && ext_q[0].cyc < cyc) begin
        ext_e = ext_q.pop_front();
        checks++; errors++;
        $display("FAIL ext_response_missing expected at cycle %0d, now %0d", ext_e.cyc, cyc);
      end
      if (bus.ext_rvalid || bus.ext_err) begin
        checks++;
        if (ext_q.size() == 0) begin
          errors++;
          $display("FAIL ext_response_unexpected rvalid %b err %b", bus.ext_rvalid, bus.ext_err);
        end else begin
          ext_e = ext_q.pop_front();
          if (bus.ext_rvalid !== ext_e.is_read || bus.ext_err !== ext_e.err || cyc != ext_e.cyc ||
              (ext_e.is_read && bus.ext_rdata !== ext_e.data)) begin
            errors++;
            $display("FAIL ext_response got rvalid %b err %b data %h cyc %0d, expected rvalid %b err %b data %h cyc %0d",
                     bus.ext_rvalid, bus.ext_err, bus.ext_rdata, cyc,
                     ext_e.is_read, ext_e.err, ext_e.data, ext_e.cyc);
          end
        end
      end
    end
  end

  task automatic ext_op(input logic we, input int bank, input int addr, input logic [31:0] wd,
                        input logic [3:0] be);
    int n = 0;
    logic ok;
    @(negedge clk);
    bus.ext_req = 1'b1; bus.ext_we = we; bus.ext_bank = BW'(bank);
    bus.ext_addr = AW'(addr); bus.ext_wdata = wd; bus.ext_be = be;
    #1;
    while (!bus.ext_ready && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (!bus.ext_ready) begin
      errors++;
      $display("FAIL ext_grant_timeout bank %0d addr %0d ready %b", bank, addr, bus.ext_ready);
    end else begin
      ok = (bank < NB) && (addr < DEPTH);
      if (ok && we) begin
        for (int i = 0; i < 4; i++) if (be[i]) model[bank][addr][i*8 +: 8] = wd[i*8 +: 8];
      end
      if (!ok || !we) ext_q.push_back('{ok ? model[bank][addr] : 32'h0, !we, !ok, cyc + 1});
    end
    @(posedge clk); #1;
    bus.ext_req = 1'b0;
  endtask

  task automatic pe_op(input int r, input logic we, input int addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    bus.pe_req[r] = 1'b1; bus.pe_we[r] = we;
    bus.pe_addr[r*AW +: AW] = AW'(addr); bus.pe_wdata[r*DW +: DW] = wd;
    #1;
    while (!bus.pe_ready[r] && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (!bus.pe_ready[r]) begin
      errors++;
      $display("FAIL pe_grant_timeout port %0d ready %b", r, bus.pe_ready[r]);
    end else if (we) begin
      if (addr < DEPTH) model[r][addr] = wd;
    end else begin
      pe_q[r].push_back('{(addr < DEPTH) ? model[r][addr] : 32'h0, cyc + 1});
    end
    @(posedge clk); #1;
    bus.pe_req[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pe_rvalid !== '0 || bus.ext_rvalid !== 1'b0 || bus.ext_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid pe_rvalid %b ext_rvalid %b ext_err %b, expected all 0",
               bus.pe_rvalid, bus.ext_rvalid, bus.ext_err);
    end
    checks++;
    if (bus.pe_rdata !== '0 || bus.ext_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata pe_rdata %h ext_rdata %h, expected 0", bus.pe_rdata, bus.ext_rdata);
    end
    checks++;
    if (bus.ext_ready !== 1'b0 || bus.pe_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready ext_ready %b pe_ready %b, expected 0", bus.ext_ready, bus.pe_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ext_write_pe_read();
    for (int b = 0; b < NB; b++) ext_op(1'b1, b, 3, 32'hA5A5_0000 + 32'(b), 4'hF);
    for (int r = 0; r < NB; r++) pe_op(r, 1'b0, 3, 32'h0);
  endtask

  task automatic test_byte_enable();
    ext_op(1'b1, 2, 7, 32'hFFFF_FFFF, 4'hF);
    ext_op(1'b1, 2, 7, 32'h1122_3344, 4'b0101);
    ext_op(1'b1, 2, 7, 32'h0000_0000, 4'b0000);
    ext_op(1'b0, 2, 7, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ext_rdata !== 32'hFF22_FF44) begin
      errors++;
      $display("FAIL byte_enable_hold ext_rdata %h, expected ff22ff44", bus.ext_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp;
    ext_op(1'b1, 1, 5, 32'h0000_5555, 4'hF);
    pe_op(1, 1'b1, 6, 32'h0000_6666);
    @(negedge clk);
    bus.pe_req[1] = 1'b1; bus.pe_we[1] = 1'b0; bus.pe_addr[1*AW +: AW] = AW'(6);
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_bank = BW'(1); bus.ext_addr = AW'(5);
    for (int c = 1; c <= SL + 1; c++) begin
      #1;
      exp = (c == SL + 1);
      checks++;
      if (bus.ext_ready !== exp) begin
        errors++;
        $display("FAIL starve_ext_ready cycle %0d got %b expected %b", c, bus.ext_ready, exp);
      end
      checks++;
      if (bus.pe_ready[1] !== !exp) begin
        errors++;
        $display("FAIL starve_pe_ready cycle %0d got %b expected %b", c, bus.pe_ready[1], !exp);
      end
      if (bus.pe_ready[1]) pe_q[1].push_back('{model[1][6], cyc + 1});
      if (bus.ext_ready) ext_q.push_back('{model[1][5], 1'b1, 1'b0, cyc + 1});
      @(posedge clk); #1;
      if (exp) bus.ext_req = 1'b0;
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.pe_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL starve_pe_resume got %b expected 1", bus.pe_ready[1]);
    end else pe_q[1].push_back('{model[1][6], cyc + 1});
    @(posedge clk); #1;
    bus.pe_req[1] = 1'b0;
  endtask

  task automatic test_out_of_range();
    ext_op(1'b1, 0, 999, 32'hCAFE_0999, 4'hF);
    ext_op(1'b0, 0, 1000, 32'h0, 4'h0);
    ext_op(1'b1, 0, 1000, 32'hDEAD_BEEF, 4'hF);
    pe_op(0, 1'b1, 1000, 32'hBAD0_BAD0);
    pe_op(0, 1'b0, 1000, 32'h0);
    pe_op(0, 1'b0, 999, 32'h0);
    ext_op(1'b0, 0, 3, 32'h0, 4'h0);
  endtask

  task automatic test_parallel_read();
    @(negedge clk);
    for (int r = 0; r < NB; r++) begin
      bus.pe_req[r] = 1'b1; bus.pe_we[r] = 1'b0; bus.pe_addr[r*AW +: AW] = AW'(3);
    end
    #1;
    checks++;
    if (bus.pe_ready !== 4'hF) begin
      errors++;
      $display("FAIL parallel_ready got %b expected 1111", bus.pe_ready);
    end
    for (int r = 0; r < NB; r++) if (bus.pe_ready[r]) pe_q[r].push_back('{model[r][3], cyc + 1});
    @(posedge clk); #1;
    bus.pe_req = '0;
    @(negedge clk);
    checks++;
    if (bus.pe_rvalid !== 4'hF) begin
      errors++;
      $display("FAIL parallel_rvalid got %b expected 1111", bus.pe_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_bank = BW'(3); bus.ext_addr = AW'(3);
    #1;
    checks++;
    if (bus.ext_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_grant got %b expected 1", bus.ext_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; bus.ext_req = 1'b0;
    #1;
    checks++;
    if (bus.ext_rvalid !== 1'b0 || bus.ext_err !== 1'b0 || bus.ext_rdata !== '0) begin
      errors++;
      $display("FAIL midreset_cancel rvalid %b err %b rdata %h expected 0 0 0",
               bus.ext_rvalid, bus.ext_err, bus.ext_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.pe_req[2] = 1'b1; bus.pe_we[2] = 1'b1; bus.pe_addr[2*AW +: AW] = AW'(8);
    bus.pe_wdata[2*DW +: DW] = 32'h0808_0808; model[2][8] = 32'h0808_0808;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_bank = BW'(2); bus.ext_addr = AW'(8);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dut.wait_cnt !== 3'd2) begin
      errors++;
      $display("FAIL starve_count got %0d expected 2", dut.wait_cnt);
    end
    rst_n = 1'b0; bus.ext_req = 1'b0; bus.pe_req = '0;
    #1;
    checks++;
    if (dut.wait_cnt !== 3'd0) begin
      errors++;
      $display("FAIL midreset_wait_cnt got %0d expected 0", dut.wait_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    ext_op(1'b0, 3, 3, 32'h0, 4'h0);
    pe_op(2, 1'b0, 8, 32'h0);
  endtask

  initial begin
    bus.pe_req = '0; bus.pe_we = '0; bus.pe_addr = '0; bus.pe_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_bank = '0; bus.ext_addr = '0;
    bus.ext_wdata = '0; bus.ext_be = '0;
    test_reset();
    test_ext_write_pe_read();
    test_byte_enable();
    test_starvation();
    test_out_of_range();
    test_parallel_read();
    test_reset_mid();
    repeat (4) @(negedge clk);
    for (int r = 0; r < NB; r++) begin
      checks++;
      if (pe_q[r].size() != 0) begin
        errors++;
        $display("FAIL pe_queue_drain port %0d has %0d pending, expected 0", r, pe_q[r].size());
      end
    end
    checks++;
    if (ext_q.size() != 0) begin
      errors++;
      $display("FAIL ext_queue_drain has %0d pending, expected 0", ext_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
